cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/cdb_fifo.sv | 80 ++++++++
 rtl/cdb_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter_pkg
// Purpose  : Shared constants and types for the common data bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
package cdb_arbiter_pkg;

  // Default ROB entry tag width
  localparam int CDB_ENTRY_W = 4;

  // Width of every data word carried on the bus
  localparam int CDB_DATA_W = 32;

  // Result source encoding as seen on cdb_src
  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

endpackage
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cdb_fifo
// Purpose  : Small synchronous FIFO with synchronous flush and a global
//            enable. Push/pop are trusted to be pre-qualified by the owner.
// Revision : 1.0  initial release
// ============================================================================
module cdb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             en,         // low freezes all state
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (en) begin
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push) begin
          mem_d[wr_ptr_q] = push_data;
          wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Control state register; reset wins over the enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Queues ALU and load results in per-source FIFOs and broadcasts
//            at most one per cycle on the registered common data bus, using
//            round-robin when both sources have results waiting.
// Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ENTRY_W = CDB_ENTRY_W,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,          // synchronous, active-low
  input  logic               rdy,
  input  logic               rollback,
  input  logic               alu_valid,
  input  logic [ENTRY_W-1:0] alu_entry,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        alu_pc,
  input  logic [31:0]        alu_pc_init,
  output logic               alu_ready,
  input  logic               lsb_valid,
  input  logic [ENTRY_W-1:0] lsb_entry,
  input  logic [31:0]        lsb_result,
  output logic               lsb_ready,
  output logic               cdb_valid,
  output logic [ENTRY_W-1:0] cdb_entry,
  output logic [31:0]        cdb_result,
  output logic [31:0]        cdb_pc,
  output logic [31:0]        cdb_pc_init,
  output logic               cdb_src
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ALU_W = 3 * CDB_DATA_W + ENTRY_W;
  localparam int LSB_W = CDB_DATA_W + ENTRY_W;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [AW:0]      alu_count, lsb_count;
  logic [ALU_W-1:0] alu_head;
  logic [LSB_W-1:0] lsb_head;
  logic             alu_push, lsb_push;
  logic             grant_alu, grant_lsb;

  cdb_src_e         last_grant_q, last_grant_d;
  logic             cdb_valid_q,  cdb_valid_d;
  logic [ENTRY_W-1:0] cdb_entry_q, cdb_entry_d;
  logic [31:0]      cdb_result_q, cdb_result_d;
  logic [31:0]      cdb_pc_q,     cdb_pc_d;
  logic [31:0]      cdb_pc_init_q, cdb_pc_init_d;
  cdb_src_e         cdb_src_q,    cdb_src_d;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even in a cycle where it is also being popped.
  assign alu_ready = (alu_count < FULL_COUNT) && rdy;
  assign lsb_ready = (lsb_count < FULL_COUNT) && rdy;
  assign alu_push  = alu_valid && alu_ready && !rollback;
  assign lsb_push  = lsb_valid && lsb_ready && !rollback;

  cdb_fifo #(
    .WIDTH (ALU_W),
    .DEPTH (DEPTH)
  ) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .flush     (rollback),
    .push      (alu_push),
    .push_data ({alu_entry, alu_result, alu_pc, alu_pc_init}),
    .pop       (grant_alu),
    .head_data (alu_head),
    .count     (alu_count)
  );

  cdb_fifo #(
    .WIDTH (LSB_W),
    .DEPTH (DEPTH)
  ) u_lsb_fifo (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .flush     (rollback),
    .push      (lsb_push),
    .push_data ({lsb_entry, lsb_result}),
    .pop       (grant_lsb),
    .head_data (lsb_head),
    .count     (lsb_count)
  );

  // Grant from registered occupancy only: same-cycle pushes wait a cycle
  always_comb begin
    grant_alu = 1'b0;
    grant_lsb = 1'b0;
    if (rdy && !rollback) begin
      if ((alu_count != '0) &&
          ((lsb_count == '0) || (last_grant_q == CDB_SRC_LSB))) begin
        grant_alu = 1'b1;
      end else if (lsb_count != '0) begin
        grant_lsb = 1'b1;
      end
    end
  end

  // Broadcast register next-state; payload holds when nothing is granted
  always_comb begin
    last_grant_d  = last_grant_q;
    cdb_valid_d   = cdb_valid_q;
    cdb_entry_d   = cdb_entry_q;
    cdb_result_d  = cdb_result_q;
    cdb_pc_d      = cdb_pc_q;
    cdb_pc_init_d = cdb_pc_init_q;
    cdb_src_d     = cdb_src_q;
    if (rdy) begin
      cdb_valid_d = grant_alu || grant_lsb;
      if (grant_alu) begin
        cdb_entry_d   = alu_head[ALU_W-1:3*CDB_DATA_W];
        cdb_result_d  = alu_head[3*CDB_DATA_W-1:2*CDB_DATA_W];
        cdb_pc_d      = alu_head[2*CDB_DATA_W-1:CDB_DATA_W];
        cdb_pc_init_d = alu_head[CDB_DATA_W-1:0];
        cdb_src_d     = CDB_SRC_ALU;
        last_grant_d  = CDB_SRC_ALU;
      end else if (grant_lsb) begin
        cdb_entry_d   = lsb_head[LSB_W-1:CDB_DATA_W];
        cdb_result_d  = lsb_head[CDB_DATA_W-1:0];
        cdb_pc_d      = '0;
        cdb_pc_init_d = '0;
        cdb_src_d     = CDB_SRC_LSB;
        last_grant_d  = CDB_SRC_LSB;
      end
    end
  end

  // Arbiter and broadcast registers; reset clears everything regardless of rdy
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q  <= CDB_SRC_LSB;
      cdb_valid_q   <= 1'b0;
      cdb_entry_q   <= '0;
      cdb_result_q  <= '0;
      cdb_pc_q      <= '0;
      cdb_pc_init_q <= '0;
      cdb_src_q     <= CDB_SRC_ALU;
    end else begin
      last_grant_q  <= last_grant_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_entry_q   <= cdb_entry_d;
      cdb_result_q  <= cdb_result_d;
      cdb_pc_q      <= cdb_pc_d;
      cdb_pc_init_q <= cdb_pc_init_d;
      cdb_src_q     <= cdb_src_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_entry   = cdb_entry_q;
  assign cdb_result  = cdb_result_q;
  assign cdb_pc      = cdb_pc_q;
  assign cdb_pc_init = cdb_pc_init_q;
  assign cdb_src     = cdb_src_q;

endmodule
`default_nettype wire
